// File: rtl/ixc_nib_bus_pkg.sv
// Shared types and helpers for the nibble bus port.
// Used by the port FSM and the pad wrapper.
package ixc_nib_bus_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX      = 3'd1,
    ST_TURN    = 3'd2,
    ST_RX_WAIT = 3'd3,
    ST_RX      = 3'd4
  } nib_state_e;

  function automatic int nib_cnt(input int word_w);
    return word_w / NIB_W;
  endfunction

endpackage

// File: rtl/ixc_nib_bus_pad.sv
// Tristate wrapper for the shared nibble bus and strobe nets.
// Drives both nets only while oe is high; always returns what is on the wire.
module ixc_nib_bus_pad
  import ixc_nib_bus_pkg::*;
(
  input  logic [NIB_W-1:0] dout_i,
  input  logic             oe_i,
  input  logic             stb_i,
  output logic [NIB_W-1:0] din_o,
  output logic             stb_o,
  inout  wire  [NIB_W-1:0] bus_io,
  inout  wire              stb_io
);

  assign bus_io = oe_i ? dout_i : {NIB_W{1'bz}};
  assign stb_io = oe_i ? stb_i : 1'bz;

  assign din_o = bus_io;
  assign stb_o = stb_io;

endmodule

// File: rtl/ixc_nib_bus_port.sv
// Active end of the 4-bit nibble bus: serialises words out,
// turns the bus around and collects words driven by the peer.
module ixc_nib_bus_port
  import ixc_nib_bus_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int TURN_CYC   = 1,
  parameter int RX_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              rx_req,
  output logic              rx_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_abort,
  output logic [NIB_W-1:0]  bus_o,
  output logic              bus_oe,
  output logic              bus_stb_o,
  input  logic [NIB_W-1:0]  bus_i,
  input  logic              bus_stb_i,
  output logic              busy
);

  localparam int NIB_CNT = nib_cnt(WORD_W);
  localparam int CNT_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
  localparam int TC_W    = $clog2(TURN_CYC + 1);
  localparam int SH_W    = WORD_W - NIB_W;

  localparam logic [CNT_W-1:0] LAST_NIB  = CNT_W'(NIB_CNT - 1);
  localparam logic [TC_W-1:0]  TURN_LAST = TC_W'(TURN_CYC);
  localparam logic [7:0]       TMO_LAST  = 8'(RX_TIMEOUT - 1);

  nib_state_e state_q, state_d;
  nib_state_e tgt_q, tgt_d;

  logic [CNT_W-1:0]  nib_q, nib_d;
  logic [TC_W-1:0]   turn_q, turn_d;
  logic [TC_W-1:0]   rel_q, rel_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [SH_W-1:0]   tx_sh_q, tx_sh_d;
  logic [SH_W-1:0]   rx_sh_q, rx_sh_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_abort_q, rx_abort_d;
  logic [NIB_W-1:0]  bus_o_q, bus_o_d;
  logic              oe_q, oe_d;
  logic              stb_q, stb_d;
  logic              tx_ready_w;

  // rel_q counts idle cycles since we last released the bus
  assign rel_d = oe_q ? '0 :
                 (rel_q == TURN_LAST) ? rel_q : rel_q + TC_W'(1);

  assign tx_ready_w = (state_q == ST_IDLE) && (rel_q == TURN_LAST);

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    nib_d      = nib_q;
    turn_d     = turn_q;
    tmo_d      = '0;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_abort_d = 1'b0;
    bus_o_d    = bus_o_q;
    oe_d       = oe_q;
    stb_d      = stb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_w) begin
          state_d = ST_TX;
          nib_d   = '0;
          bus_o_d = tx_data[NIB_W-1:0];
          tx_sh_d = tx_data[WORD_W-1:NIB_W];
          oe_d    = 1'b1;
          stb_d   = 1'b1;
        end else if (rx_req) begin
          state_d = ST_TURN;
          tgt_d   = ST_RX_WAIT;
          turn_d  = '0;
        end
      end
      ST_TX: begin
        if (nib_q == LAST_NIB) begin
          state_d = ST_TURN;
          tgt_d   = ST_IDLE;
          turn_d  = '0;
          bus_o_d = '0;
          oe_d    = 1'b0;
          stb_d   = 1'b0;
        end else begin
          nib_d   = nib_q + CNT_W'(1);
          bus_o_d = tx_sh_q[NIB_W-1:0];
          tx_sh_d = tx_sh_q >> NIB_W;
        end
      end
      // first TURN cycle is the release itself, then TURN_CYC idle ones
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = tgt_q;
          nib_d   = '0;
        end else begin
          turn_d = turn_q + TC_W'(1);
        end
      end
      ST_RX_WAIT: begin
        if (bus_stb_i) begin
          rx_sh_d = (rx_sh_q >> NIB_W) | (SH_W'(bus_i) << (SH_W - NIB_W));
          nib_d   = CNT_W'(1);
          state_d = ST_RX;
        end else if (tmo_q == TMO_LAST) begin
          rx_abort_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        end
      end
      ST_RX: begin
        if (!bus_stb_i) begin
          rx_abort_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (nib_q == LAST_NIB) begin
          rx_data_d  = {bus_i, rx_sh_q};
          rx_valid_d = 1'b1;
          state_d    = ST_TURN;
          tgt_d      = ST_IDLE;
          turn_d     = '0;
        end else begin
          rx_sh_d = (rx_sh_q >> NIB_W) | (SH_W'(bus_i) << (SH_W - NIB_W));
          nib_d   = nib_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tgt_q      <= ST_IDLE;
      nib_q      <= '0;
      turn_q     <= '0;
      rel_q      <= '0;
      tmo_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
      bus_o_q    <= '0;
      oe_q       <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      nib_q      <= nib_d;
      turn_q     <= turn_d;
      rel_q      <= rel_d;
      tmo_q      <= tmo_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_abort_q <= rx_abort_d;
      bus_o_q    <= bus_o_d;
      oe_q       <= oe_d;
      stb_q      <= stb_d;
    end
  end

  assign tx_ready  = tx_ready_w;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_abort  = rx_abort_q;
  assign bus_o     = bus_o_q;
  assign bus_oe    = oe_q;
  assign bus_stb_o = stb_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ixc_nib_bus_port.sv
// Bench for ixc_nib_bus_port: vector table plus beat/word scoreboards.
// Peer side is modelled on a real tristate net through the pad wrapper.
module tb_ixc_nib_bus_port;
  import ixc_nib_bus_pkg::*;

  localparam int W          = 32;
  localparam int TURN_CYC   = 1;
  localparam int RX_TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [W-1:0]  tx_data = '0;
  logic          rx_req = 1'b0;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic          rx_abort;
  logic [3:0]    bus_o;
  logic          bus_oe;
  logic          bus_stb_o;
  logic [3:0]    bus_i;
  logic          bus_stb_i;
  logic          busy;

  logic [3:0]    peer_nib = '0;
  logic          peer_stb = 1'b0;
  wire  [3:0]    bus_net;
  wire           stb_net;

  always #5 clk = ~clk;

  // peer holds the net whenever we are not driving it
  assign bus_net = bus_oe ? 4'bzzzz : peer_nib;
  assign stb_net = bus_oe ? 1'bz : peer_stb;

  ixc_nib_bus_pad u_pad (
    .dout_i (bus_o),
    .oe_i   (bus_oe),
    .stb_i  (bus_stb_o),
    .din_o  (bus_i),
    .stb_o  (bus_stb_i),
    .bus_io (bus_net),
    .stb_io (stb_net)
  );

  ixc_nib_bus_port #(
    .WORD_W     (W),
    .TURN_CYC   (TURN_CYC),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_req    (rx_req),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_abort  (rx_abort),
    .bus_o     (bus_o),
    .bus_oe    (bus_oe),
    .bus_stb_o (bus_stb_o),
    .bus_i     (bus_i),
    .bus_stb_i (bus_stb_i),
    .busy      (busy)
  );

  typedef struct {
    logic        rx;
    logic [31:0] din;
    logic [31:0] dexp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  txq[$];
  logic [31:0] rxq[$];
  logic [31:0] last_rx = '0;
  int          gap = 1000;
  logic        oe_prev = 1'b0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // beat and word scoreboards
  always @(negedge clk) begin
    if (bus_stb_o) begin
      if (txq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_stray: beat %h with no word pending", bus_o);
      end else begin
        chk("tx_beat", {28'd0, bus_o}, {28'd0, txq.pop_front()});
        chk("tx_oe", {31'd0, bus_oe}, 32'd1);
      end
    end
    if (rx_valid) begin
      if (rxq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_stray: rx_valid with data %h", rx_data);
      end else begin
        last_rx = rxq.pop_front();
        chk("rx_word", rx_data, last_rx);
      end
    end
    if (bus_oe && !oe_prev)
      chk("turn_gap", {31'd0, gap >= TURN_CYC}, 32'd1);
    if (bus_oe) gap = 0;
    else if (gap < 1000) gap++;
    oe_prev = bus_oe;
  end

  task automatic wait_ready();
    int n = 0;
    while (!(tx_ready && !busy) && n < 50) begin
      tick();
      n++;
    end
    chk("wait_ready", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic push_beats(input logic [31:0] seq);
    for (int k = 0; k < 8; k++) txq.push_back(seq[31-4*k -: 4]);
  endtask

  task automatic peer_beats(input logic [31:0] seq, input int n);
    for (int k = 0; k < n; k++) begin
      peer_stb = 1'b1;
      peer_nib = seq[31-4*k -: 4];
      chk("rx_oe_low", {31'd0, bus_oe}, 32'd0);
      tick();
    end
    peer_stb = 1'b0;
    peer_nib = '0;
  endtask

  // current negedge: rx_req was just sampled-to-be; drop it, wait out TURN
  task automatic rx_turn();
    tick();
    rx_req = 1'b0;
    repeat (TURN_CYC + 1) tick();
  endtask

  initial begin
    int cnt;
    logic [31:0] hold;

    vecs[0] = '{1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[1] = '{1'b1, 32'h12345678, 32'h87654321};
    vecs[2] = '{1'b0, 32'h12345678, 32'h87654321};
    vecs[3] = '{1'b0, 32'hFFFF0000, 32'h0000FFFF};
    vecs[4] = '{1'b1, 32'hDEADBEEF, 32'hFEEBDAED};
    vecs[5] = '{1'b0, 32'h0F1E2D3C, 32'hC3D2E1F0};
    vecs[6] = '{1'b1, 32'h0123ABCD, 32'hDCBA3210};

    repeat (2) tick();
    chk("rst_outs", {25'd0, tx_ready, rx_valid, rx_abort, bus_oe,
                     bus_stb_o, busy, bus_o}, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wait_ready();
      if (!vecs[i].rx) begin
        tx_valid = 1'b1;
        tx_data  = vecs[i].din;
        push_beats(vecs[i].dexp);
        tick();
        tx_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
          cnt++;
          tick();
        end
        chk("tx_busy_len", cnt, 9 + TURN_CYC);
        chk("tx_drained", txq.size(), 0);
      end else begin
        rx_req = 1'b1;
        rxq.push_back(vecs[i].dexp);
        rx_turn();
        peer_beats(vecs[i].din, 8);
        repeat (3) tick();
        chk("rx_done", rxq.size(), 0);
      end
    end

    // TX and RX requested together: TX first, RX afterwards
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = 32'hC0DE1234;
    rx_req   = 1'b1;
    push_beats(32'h4321ED0C);
    rxq.push_back(32'h86427531);
    tick();
    tx_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("both_tx_first", txq.size(), 0);
    chk("both_tx_len", cnt, 9 + TURN_CYC);
    rx_turn();
    peer_beats(32'h13572468, 8);
    repeat (3) tick();
    chk("both_rx_done", rxq.size(), 0);

    // RX timeout with silent peer
    wait_ready();
    rx_req = 1'b1;
    tick();
    rx_req = 1'b0;
    cnt = 1;
    while (!rx_abort && cnt < 600) begin
      tick();
      cnt++;
    end
    chk("rx_timeout_cyc", cnt, TURN_CYC + 2 + RX_TIMEOUT);
    tick();
    chk("abort_pulse", {31'd0, rx_abort}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // strobe breaks after four nibbles
    wait_ready();
    hold = last_rx;
    rx_req = 1'b1;
    rx_turn();
    peer_beats(32'hFACE0000, 4);
    tick();
    chk("brk_abort", {31'd0, rx_abort}, 32'd1);
    chk("brk_rx_data", rx_data, hold);
    tick();
    chk("brk_pulse", {31'd0, rx_abort}, 32'd0);
    chk("brk_idle", {31'd0, busy}, 32'd0);

    // asynchronous reset during TX beat 3
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = 32'h76543210;
    push_beats(32'h01234567);
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", {31'd0, bus_oe}, 32'd0);
    chk("arst_stb", {31'd0, bus_stb_o}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_beats_left", txq.size(), 4);
    txq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rel_idle", {31'd0, busy}, 32'd0);
    chk("rel_ready", {31'd0, tx_ready}, 32'd1);
    chk("rel_oe", {31'd0, bus_oe}, 32'd0);
    repeat (12) tick();
    chk("end_txq", txq.size(), 0);
    chk("end_rxq", rxq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
